// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the round-robin FIFO arbiter.
//   N_PORTS   : number of input and output FIFOs (fixed at 4)
//   DEST_MSB/DEST_LSB : bit range of the destination field inside a FIFO word
//   state_t   : arbiter FSM encoding (IDLE, BURST)
package arbitro_rr_pkg;

  localparam int N_PORTS  = 4;
  localparam int DEST_MSB = 9;
  localparam int DEST_LSB = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/arbitro_rr_rr_select.sv
// Rotating-priority search over four requesters.
//   eligible : request vector, bit i = input i may be served
//   ptr      : index with highest priority this cycle (search ptr, ptr+1, ... mod 4)
//   grant    : one-hot winner, zero when nothing is eligible
//   any      : at least one eligible input
module rr_select (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |eligible;
    for (int j = 0; j < 4; j++) begin
      idx = ptr + 2'(j);
      if ((grant == 4'b0000) && eligible[idx]) begin
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Weighted round-robin arbiter moving words from four show-ahead input
// FIFOs to four output FIFOs selected by each word's destination field.
//   clk         : single clock, rising edge
//   reset       : synchronous, active-low
//   empty       : empty flags of input FIFOs 0..3
//   data_in0..3 : head word of each input FIFO (valid when not empty)
//   almost_full : almost-full flags of output FIFOs 0..3
//   weight      : 2 bits per input; a burst holds up to weight+1 pops
//   pop         : one-hot read strobe to the input FIFOs
//   push        : one-hot write strobe to the output FIFOs, one cycle after pop
//   data_out    : registered word accompanying push
//   idle        : FSM idle and no push in flight
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int N_PORTS = arbitro_rr_pkg::N_PORTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_PORTS-1:0]     empty,
  input  logic [DATA_W-1:0]      data_in0,
  input  logic [DATA_W-1:0]      data_in1,
  input  logic [DATA_W-1:0]      data_in2,
  input  logic [DATA_W-1:0]      data_in3,
  input  logic [N_PORTS-1:0]     almost_full,
  input  logic [2*N_PORTS-1:0]   weight,
  output logic [N_PORTS-1:0]     pop,
  output logic [N_PORTS-1:0]     push,
  output logic [DATA_W-1:0]      data_out,
  output logic                   idle
);

  logic [DATA_W-1:0]  din [4];
  logic [1:0]         dest [4];
  logic [3:0]         eligible;

  state_t             state, state_nxt;
  logic [1:0]         ptr, ptr_nxt;
  logic [1:0]         gnt, gnt_nxt;
  logic [1:0]         rem, rem_nxt;

  logic [3:0]         sel_grant;
  logic               sel_any;
  logic [1:0]         sel_idx;
  logic               burst_go;
  logic [3:0]         pop_c;
  logic [1:0]         pop_idx;

  logic [N_PORTS-1:0] push_p1;
  logic [DATA_W-1:0]  dout_p1;
  logic               vld_p1;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  // An input is servable only if its word's target FIFO still has room;
  // almost_full already reserves the slot for the push in flight.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 4; i++) begin
      dest[i]     = din[i][DEST_MSB:DEST_LSB];
      eligible[i] = !empty[i] && !almost_full[dest[i]];
    end
  end

  // ptr always holds (last granted + 1), so the same search serves both a
  // start from IDLE and a back-to-back start when a burst ends.
  rr_select u_rr_select (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (sel_grant),
    .any      (sel_any)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_grant[i]) begin
        sel_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    rem_nxt   = rem;
    pop_c     = '0;
    pop_idx   = gnt;
    // rem counts pops still allowed after the current one
    burst_go  = (state == BURST) && (rem != 2'd0) && eligible[gnt];
    if (burst_go) begin
      pop_c[gnt] = 1'b1;
      rem_nxt    = rem - 2'd1;
    end else if (sel_any) begin
      pop_c     = sel_grant;
      pop_idx   = sel_idx;
      gnt_nxt   = sel_idx;
      rem_nxt   = weight[2*sel_idx +: 2];
      ptr_nxt   = sel_idx + 2'd1;
      state_nxt = BURST;
    end else begin
      state_nxt = IDLE;
    end
  end

  assign pop = reset ? N_PORTS'(pop_c) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      rem   <= rem_nxt;
    end
  end

  // ---- stage p1: word popped this cycle is pushed next cycle ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      push_p1 <= '0;
      dout_p1 <= '0;
    end else if (pop_c != 4'b0000) begin
      push_p1 <= N_PORTS'(1) << dest[pop_idx];
      dout_p1 <= din[pop_idx];
    end else begin
      push_p1 <= '0;
    end
  end

  assign vld_p1   = |push_p1;
  // A push left over from the cycle before reset must not reach the FIFO.
  assign push     = push_p1 & {N_PORTS{reset}};
  assign data_out = dout_p1;
  assign idle     = (state == IDLE) && !vld_p1;

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: input FIFOs are bench queues, a burst-level
// reference model predicts each pop, and a scoreboard checks every push.
module tb_arbitro_rr;

  logic        clk;
  logic        reset;
  logic [3:0]  empty;
  logic [11:0] din [4];
  logic [3:0]  almost_full;
  logic [7:0]  weight;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [11:0] data_out;
  logic        idle;

  arbitro_rr #(.DATA_W(12), .N_PORTS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .data_in0    (din[0]),
    .data_in1    (din[1]),
    .data_in2    (din[2]),
    .data_in3    (din[3]),
    .almost_full (almost_full),
    .weight      (weight),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  push;
    logic [11:0] data;
    time         t;
  } sb_t;

  sb_t         sb [$];
  logic [11:0] fq [4][$];
  int          tests = 0;
  int          fails = 0;

  // bench-side stimulus values, applied each cycle by tick()
  logic        rst_v;
  logic [3:0]  af_v;
  logic [7:0]  wgt_v;
  logic [3:0]  last_pop;

  // reference model: current burst owner (-1 none), pops used, limit, rotation start
  int          owner = -1;
  int          used  = 0;
  int          lim   = 0;
  int          mptr  = 0;
  bit          inflight = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    int          exp_idx;
    logic [3:0]  exp_pop;
    bit          elig [4];
    logic [11:0] hw;
    bit          was_idle;
    sb_t         e;
    @(posedge clk);
    #1;
    reset       = rst_v;
    almost_full = af_v;
    weight      = wgt_v;
    if (!rst_v) sb.delete();
    for (int i = 0; i < 4; i++) begin
      empty[i] = (fq[i].size() == 0);
      din[i]   = (fq[i].size() != 0) ? fq[i][0] : 12'hFFF;
    end
    #3;
    last_pop = pop;
    exp_pop  = '0;
    exp_idx  = -1;
    if (rst_v) begin
      was_idle = (owner < 0);
      for (int i = 0; i < 4; i++) begin
        elig[i] = 1'b0;
        if (fq[i].size() != 0) begin
          hw = fq[i][0];
          elig[i] = !af_v[hw[9:8]];
        end
      end
      if (owner >= 0 && used <= lim && elig[owner]) begin
        exp_idx = owner;
        used++;
      end else begin
        if (owner >= 0) begin
          mptr  = (owner + 1) % 4;
          owner = -1;
        end
        for (int j = 0; j < 4; j++) begin
          int k;
          k = (mptr + j) % 4;
          if (elig[k] && exp_idx < 0) begin
            exp_idx = k;
            owner   = k;
            used    = 1;
            lim     = int'((wgt_v >> (2 * k)) & 8'h3);
          end
        end
      end
      chk("idle", {31'd0, idle}, {31'd0, (was_idle && !inflight)});
    end
    if (exp_idx >= 0) exp_pop[exp_idx] = 1'b1;
    chk("pop", {28'd0, pop}, {28'd0, exp_pop});
    if (exp_idx >= 0) begin
      hw     = fq[exp_idx].pop_front();
      e.push = 4'b0001 << hw[9:8];
      e.data = hw;
      e.t    = $time;
      sb.push_back(e);
    end
    inflight = (exp_idx >= 0);
    if (!rst_v) begin
      owner = -1; used = 0; mptr = 0; inflight = 0;
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) fq[i].delete();
  endtask

  task automatic do_reset();
    rst_v = 1'b0;
    tick();
    tick();
  endtask

  // monitor: a push is due exactly one cycle after its pop was observed
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #3;
      tests++;
      if (sb.size() > 0 && ($time - sb[0].t) >= 9) begin
        e = sb.pop_front();
        if (push !== e.push || data_out !== e.data) begin
          fails++;
          $display("FAIL push_chk: push=%b data=%h expected push=%b data=%h at %0t",
                   push, data_out, e.push, e.data, $time);
        end
      end else if (push !== 4'b0000) begin
        fails++;
        $display("FAIL push_unexp: push=%b data=%h expected push=0000 at %0t", push, data_out, $time);
      end
    end
  end

  initial begin
    logic [3:0] seq [5];
    reset = 1'b0; almost_full = '0; weight = '0; empty = '1;
    for (int i = 0; i < 4; i++) din[i] = '0;
    rst_v = 1'b0; af_v = '0; wgt_v = '0;

    // reset with every input loaded, then rotation with weight 0
    clear_q();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 3; n++) fq[i].push_back(12'($urandom));
    do_reset();
    tick();
    chk("rst_push", {28'd0, push}, 32'h0);
    chk("rst_data", {20'd0, data_out}, 32'h0);
    chk("rst_idle", {31'd0, idle}, 32'h1);
    rst_v = 1'b1;
    for (int k = 0; k < 5; k++) begin tick(); seq[k] = last_pop; end
    chk("rot0", {28'd0, seq[0]}, 32'h1);
    chk("rot1", {28'd0, seq[1]}, 32'h2);
    chk("rot2", {28'd0, seq[2]}, 32'h4);
    chk("rot3", {28'd0, seq[3]}, 32'h8);
    chk("rot4", {28'd0, seq[4]}, 32'h1);

    // weight 3 on port 0
    clear_q();
    for (int n = 0; n < 5; n++) fq[0].push_back(12'h010 + 12'(n));
    fq[1].push_back(12'h121); fq[1].push_back(12'h122);
    wgt_v = 8'b00_00_00_11;
    do_reset();
    rst_v = 1'b1;
    for (int k = 0; k < 5; k++) begin tick(); seq[k] = last_pop; end
    chk("wgt0", {28'd0, seq[0]}, 32'h1);
    chk("wgt3", {28'd0, seq[3]}, 32'h1);
    chk("wgt4", {28'd0, seq[4]}, 32'h2);

    // backpressure on output 2 blocks port 0 only
    clear_q();
    fq[0].push_back(12'h200); fq[1].push_back(12'h011);
    fq[2].push_back(12'h122); fq[3].push_back(12'h333);
    wgt_v = 8'h00; af_v = 4'b0100;
    do_reset();
    rst_v = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); seq[k] = last_pop; end
    chk("bp0", {28'd0, seq[0]}, 32'h2);
    chk("bp1", {28'd0, seq[1]}, 32'h4);
    chk("bp2", {28'd0, seq[2]}, 32'h8);
    chk("bp3", {28'd0, seq[3]}, 32'h0);
    af_v = 4'b0000;
    tick();
    chk("bp_clr", {28'd0, last_pop}, 32'h1);

    // data path: port 3 word to destination 2
    clear_q();
    fq[3].push_back(12'h2A5);
    do_reset();
    rst_v = 1'b1;
    tick();
    chk("dp_pop", {28'd0, last_pop}, 32'h8);
    tick();
    chk("dp_push", {28'd0, push}, 32'h4);
    chk("dp_data", {20'd0, data_out}, 32'h2A5);

    // reset in the middle of a weight-3 burst
    clear_q();
    for (int n = 0; n < 8; n++) fq[0].push_back(12'h001 + 12'(n));
    for (int n = 0; n < 3; n++) fq[1].push_back(12'h101 + 12'(n));
    wgt_v = 8'hFF;
    do_reset();
    rst_v = 1'b1;
    tick(); tick();
    rst_v = 1'b0;
    tick();
    chk("mid_push", {28'd0, push}, 32'h0);
    tick();
    rst_v = 1'b1;
    tick();
    chk("mid_restart", {28'd0, last_pop}, 32'h1);

    // randomized traffic, backpressure, weights and occasional resets
    clear_q();
    do_reset();
    rst_v = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        int p;
        p = int'($urandom_range(3, 0));
        if (fq[p].size() < 6) fq[p].push_back(12'($urandom));
      end
      if ($urandom_range(3, 0) == 0) af_v = 4'($urandom) & 4'($urandom);
      wgt_v = 8'($urandom);
      rst_v = ($urandom_range(199, 0) != 0);
      tick();
    end

    // drain
    rst_v = 1'b1; af_v = '0;
    for (int c = 0; c < 40; c++) tick();
    @(posedge clk);
    #5;
    chk("sb_empty", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
